// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Multi-cycle controller for the 4-bit-opcode datapath. Each instruction walks
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and drives the datapath enables as
// combinational decodes of the registered state, the latched opcode, the
// memory acks and the comparator result.
//
// Optional feature: define INSTR_COUNT_EN to add the retired_count output,
// a 16-bit wrapping count of pc_write cycles (one per completed instruction).
//
// Memory handshake (instruction and data side alike): the controller raises a
// request (imem_req / dmem_read / dmem_write) on entry to FETCH or MEM and holds
// it, unchanged, every cycle until the matching ack is seen high at a rising
// clock edge; the ack completes the transfer in that same cycle. An ack seen
// in any other state is ignored. If no ack has arrived by the cycle in which
// the wait counter equals MEM_TIMEOUT, the controller parks in ERR with the
// sticky bus_error flag set until rst_n is asserted. An ack arriving in that
// final cycle still completes the transfer normally.
//
// Parameter constraints: MEM_TIMEOUT >= 1 and 2**TO_W > MEM_TIMEOUT.

module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] instr_opcode,
  input  logic       cmp_true,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_load,
  output logic       dmem_read,
  output logic       dmem_write,
  output logic       reg_write,
  output logic       immediate,
  output logic       alu_and,
  output logic       alu_add,
  output logic       comparator,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] state,
  output logic       bus_error
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_RST    = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t          state_q;
  logic [3:0]      op_q;
  logic [TO_W-1:0] wait_cnt;
  logic            bus_error_q;

  // Opcode classes, decoded from the latched opcode only, so the instruction
  // register may change freely once DECODE has passed.
  logic op_add, op_addi, op_and, op_andi;
  logic op_load, op_store, op_cmp, op_jump;
  logic op_alu, sel_add, sel_and, sel_imm;
  logic wait_expired;

  assign op_add   = (op_q == 4'b0000);
  assign op_addi  = (op_q == 4'b0001);
  assign op_and   = (op_q == 4'b0010);
  assign op_andi  = (op_q == 4'b0011);
  assign op_load  = (op_q == 4'b0100);
  assign op_store = (op_q == 4'b0101);
  assign op_cmp   = (op_q == 4'b0110);
  assign op_jump  = (op_q >= 4'b0111);

  assign op_alu  = op_add | op_addi | op_and | op_andi;
  assign sel_add = op_add | op_addi;
  assign sel_and = op_and | op_andi;
  assign sel_imm = op_addi | op_andi;

  // Last permitted wait cycle in FETCH or MEM.
  assign wait_expired = (wait_cnt == TIMEOUT_CNT);

  // Sequencer: state, latched opcode, wait counter and sticky error flag.
  // The wait counter is cleared in every cycle that does not keep waiting, so
  // it always reads zero on entry to FETCH or MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST;
      op_q        <= 4'b0000;
      wait_cnt    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      wait_cnt <= '0;
      unique case (state_q)
        S_RST: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
          end else if (wait_expired) begin
            state_q     <= S_ERR;
            bus_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_q    <= instr_opcode;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (op_alu) begin
            state_q <= S_WB;
          end else if (op_load || op_store) begin
            state_q <= S_MEM;
          end else begin
            // CMP and JUMP retire here.
            state_q <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_q <= op_load ? S_WB : S_FETCH;
          end else if (wait_expired) begin
            state_q     <= S_ERR;
            bus_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
        end
        S_ERR: begin
          // Parked until rst_n; acks are ignored.
          state_q     <= S_ERR;
          bus_error_q <= 1'b1;
        end
        default: begin
          // Unused encoding: recover through the reset state.
          state_q <= S_RST;
        end
      endcase
    end
  end

  // Datapath enables: pure decode of state, latched opcode, acks and cmp_true.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    immediate  = 1'b0;
    alu_and    = 1'b0;
    alu_add    = 1'b0;
    comparator = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_NEXT;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_EXEC: begin
        alu_add   = sel_add;
        alu_and   = sel_and;
        immediate = sel_imm;
        if (op_cmp) begin
          comparator = 1'b1;
          pc_write   = 1'b1;
          pc_src     = cmp_true ? PC_BRANCH : PC_NEXT;
        end
        if (op_jump) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
      end
      S_MEM: begin
        if (op_load) begin
          dmem_read = 1'b1;
        end else begin
          // STORE retires on the cycle its write is acknowledged.
          dmem_write = 1'b1;
          pc_write   = dmem_ack;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        // Keep the result path selected while the register file writes.
        alu_add   = sel_add;
        alu_and   = sel_and;
        immediate = sel_imm;
        dmem_read = op_load;
      end
      default: begin
        // RST, DECODE, ERR and unused encodings drive nothing.
      end
    endcase
  end

  assign state     = state_q;
  assign bus_error = bus_error_q;

`ifdef INSTR_COUNT_EN
  logic [15:0] retired_q;

  // Retired-instruction counter: one pc_write pulse per instruction, wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 16'h0000;
    end else if (pc_write) begin
      retired_q <= retired_q + 16'h0001;
    end
  end

  assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
// Cycle-by-cycle bench for multicycle_sequencer. Each scenario pushes the
// expected {state, outputs} vector for every cycle together with the inputs
// to apply in that cycle, then steps the DUT and compares at the falling edge.
// Define INSTR_COUNT_EN to also cover the retired_count output.

module tb_multicycle_sequencer;

  localparam int W = 16;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_RST    = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd7;

  // Output bits: imem_req, ir_load, dmem_read, dmem_write, reg_write,
  // immediate, alu_and, alu_add, comparator, pc_write, pc_src[1:0], bus_error
  localparam logic [12:0] O_NONE = 13'h0000;
  localparam logic [12:0] O_REQ  = 13'h1000;
  localparam logic [12:0] O_IRL  = 13'h0800;
  localparam logic [12:0] O_DRD  = 13'h0400;
  localparam logic [12:0] O_DWR  = 13'h0200;
  localparam logic [12:0] O_RW   = 13'h0100;
  localparam logic [12:0] O_IMM  = 13'h0080;
  localparam logic [12:0] O_AND  = 13'h0040;
  localparam logic [12:0] O_ADD  = 13'h0020;
  localparam logic [12:0] O_CMP  = 13'h0010;
  localparam logic [12:0] O_PCW  = 13'h0008;
  localparam logic [12:0] O_JMP  = 13'h0004;
  localparam logic [12:0] O_BR   = 13'h0002;
  localparam logic [12:0] O_BERR = 13'h0001;

  logic       clk;
  logic       rst_n;
  logic [3:0] instr_opcode;
  logic       cmp_true;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       ir_load;
  logic       dmem_read;
  logic       dmem_write;
  logic       reg_write;
  logic       immediate;
  logic       alu_and;
  logic       alu_add;
  logic       comparator;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic       bus_error;
`ifdef INSTR_COUNT_EN
  logic [15:0] retired_count;
`endif

  logic [W-1:0] exp_q[$];
  logic [6:0]   in_q[$];
  int errors = 0;
  int checks = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_opcode (instr_opcode),
    .cmp_true     (cmp_true),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .reg_write    (reg_write),
    .immediate    (immediate),
    .alu_and      (alu_and),
    .alu_add      (alu_add),
    .comparator   (comparator),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .state        (state),
    .bus_error    (bus_error)
`ifdef INSTR_COUNT_EN
    ,
    .retired_count(retired_count)
`endif
  );

  // Clock and run-time guard
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [12:0] o);
    return {st, o};
  endfunction

  function automatic logic [6:0] iv(input logic im, input logic dm, input logic cp,
                                    input logic [3:0] op);
    return {im, dm, cp, op};
  endfunction

  function automatic logic [W-1:0] obs();
    return {state, imem_req, ir_load, dmem_read, dmem_write, reg_write, immediate,
            alu_and, alu_add, comparator, pc_write, pc_src, bus_error};
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(0, 15));
  endfunction

  // Driver tasks
  task automatic push(input logic [W-1:0] e, input logic [6:0] i);
    exp_q.push_back(e);
    in_q.push_back(i);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    dmem_ack     = 1'b0;
    cmp_true     = 1'b0;
    instr_opcode = 4'h0;
    exp_q.delete();
    in_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    imem_ack     = 1'b1;
    dmem_ack     = 1'b1;
    cmp_true     = 1'b1;
    instr_opcode = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== ev(ST_RST, O_NONE)) begin
      errors++;
      $display("FAIL reset: got %b, expected %b", obs(), ev(ST_RST, O_NONE));
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (retired_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, expected 0", retired_count);
    end
`endif
  endtask

  task automatic test_alu();
    logic [W-1:0] got, want;
    logic [12:0]  sel;
    logic [3:0]   op;
    int cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 4; k++) begin
      op  = 4'(k);
      sel = (k == 0) ? O_ADD : (k == 1) ? (O_ADD | O_IMM) :
            (k == 2) ? O_AND : (O_AND | O_IMM);
      push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, ~op));
      push(ev(ST_DECODE, O_NONE), iv(1'b1, 1'b0, 1'b0, op));
      push(ev(ST_EXEC, sel), iv(1'b1, 1'b1, 1'b1, rnd_op()));
      push(ev(ST_WB, sel | O_RW | O_PCW), iv(1'b1, 1'b1, 1'b0, rnd_op()));
    end
    push(ev(ST_FETCH, O_REQ), iv(1'b0, 1'b0, 1'b0, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL alu cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load();
    logic [W-1:0] got, want;
    int cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, 4'h9));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b1, 1'b0, 4'h4));
    push(ev(ST_EXEC, O_NONE), iv(1'b0, 1'b1, 1'b0, 4'hB));
    for (int k = 0; k < 3; k++) push(ev(ST_MEM, O_DRD), iv(1'b1, 1'b0, 1'b0, rnd_op()));
    push(ev(ST_MEM, O_DRD), iv(1'b0, 1'b1, 1'b0, rnd_op()));
    push(ev(ST_WB, O_DRD | O_RW | O_PCW), iv(1'b0, 1'b1, 1'b0, rnd_op()));
    push(ev(ST_FETCH, O_REQ), iv(1'b0, 1'b0, 1'b0, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL load cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store();
    logic [W-1:0] got, want;
    int cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b1, 1'b0, 4'h0));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h5));
    push(ev(ST_EXEC, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h4));
    for (int k = 0; k < 2; k++) push(ev(ST_MEM, O_DWR), iv(1'b1, 1'b0, 1'b0, 4'h4));
    push(ev(ST_MEM, O_DWR | O_PCW), iv(1'b0, 1'b1, 1'b0, 4'h4));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, 4'h0));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h5));
    push(ev(ST_EXEC, O_NONE), iv(1'b0, 1'b1, 1'b0, 4'h1));
    push(ev(ST_MEM, O_DWR | O_PCW), iv(1'b0, 1'b1, 1'b0, 4'h1));
    push(ev(ST_FETCH, O_REQ), iv(1'b0, 1'b0, 1'b0, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL store cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_cmp();
    logic [W-1:0] got, want;
    int cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, 4'h0));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h6));
    push(ev(ST_EXEC, O_CMP | O_PCW | O_BR), iv(1'b0, 1'b0, 1'b1, 4'h0));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b1, 4'h0));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b1, 4'h6));
    push(ev(ST_EXEC, O_CMP | O_PCW), iv(1'b0, 1'b0, 1'b0, 4'h2));
    push(ev(ST_FETCH, O_REQ), iv(1'b0, 1'b0, 1'b1, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cmp cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jump();
    logic [W-1:0] got, want;
    logic [3:0]   ops [3];
    int cyc = 0;
    ops[0] = 4'h7;
    ops[1] = 4'hA;
    ops[2] = 4'hF;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 3; k++) begin
      push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, 4'h0));
      push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b0, ops[k]));
      push(ev(ST_EXEC, O_PCW | O_JMP), iv(1'b0, 1'b1, 1'b1, 4'h0));
    end
    push(ev(ST_FETCH, O_REQ), iv(1'b0, 1'b0, 1'b0, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL jump cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fetch_timeout();
    logic [W-1:0] got, want;
    int cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 16; k++) push(ev(ST_FETCH, O_REQ), iv(1'b0, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 3; k++) push(ev(ST_ERR, O_BERR), iv(1'b1, 1'b1, 1'b1, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fetch_timeout cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    // Asynchronous reset out of ERR, checked between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== ev(ST_RST, O_NONE)) begin
      errors++;
      $display("FAIL err_reset: got %b, expected %b", obs(), ev(ST_RST, O_NONE));
    end

    // Ack on the last permitted cycle still completes the fetch.
    cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 15; k++) push(ev(ST_FETCH, O_REQ), iv(1'b0, 1'b0, 1'b0, 4'h0));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, 4'h0));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    push(ev(ST_EXEC, O_ADD), iv(1'b0, 1'b0, 1'b0, 4'h3));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fetch_last_ack cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_timeout();
    logic [W-1:0] got, want;
    int cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, 4'h0));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h4));
    push(ev(ST_EXEC, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 16; k++) push(ev(ST_MEM, O_DRD), iv(1'b1, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 2; k++) push(ev(ST_ERR, O_BERR), iv(1'b1, 1'b1, 1'b0, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mem_timeout cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [W-1:0] got, want;
    int cyc = 0;
    do_reset();
    push(ev(ST_RST, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    push(ev(ST_FETCH, O_REQ | O_IRL), iv(1'b1, 1'b0, 1'b0, 4'h0));
    push(ev(ST_DECODE, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h5));
    push(ev(ST_EXEC, O_NONE), iv(1'b0, 1'b0, 1'b0, 4'h0));
    for (int k = 0; k < 2; k++) push(ev(ST_MEM, O_DWR), iv(1'b0, 1'b0, 1'b0, 4'h0));
    while (exp_q.size() > 0) begin
      {imem_ack, dmem_ack, cmp_true, instr_opcode} = in_q.pop_front();
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL store_pre_reset cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                 cyc, got[15:13], got[12:0], want[15:13], want[12:0]);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    // Still in MEM with the write pending: drop rst_n between edges.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== ev(ST_RST, O_NONE)) begin
      errors++;
      $display("FAIL mid_store_reset: got %b, expected %b", obs(), ev(ST_RST, O_NONE));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

`ifdef INSTR_COUNT_EN
  task automatic test_retired_count();
    do_reset();
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    cmp_true = 1'b0;
    // Program: ADD (4 cycles), CMP (3 cycles), STORE (4 cycles).
    for (int k = 0; k < 12; k++) begin
      instr_opcode = (k <= 4) ? 4'h0 : (k <= 7) ? 4'h6 : 4'h5;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (retired_count !== 16'd3 || state !== ST_FETCH) begin
      errors++;
      $display("FAIL retired_count: got count=%0d state=%0d, expected count=3 state=%0d",
               retired_count, state, ST_FETCH);
    end
  endtask
`endif

  // Test sequence and final report
  initial begin
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    dmem_ack     = 1'b0;
    cmp_true     = 1'b0;
    instr_opcode = 4'h0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_cmp();
    test_jump();
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_mid_store();
`ifdef INSTR_COUNT_EN
    test_retired_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
